dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port data memory (async read, sync write, word-indexed by addr[31:2])
//  between two requesters: M0 = core load/store unit, M1 = debug/DMA port.
//  Round-robin arbitration, one transaction in flight, byte-enable stores via read-modify-write.
//  Sits between the requesters and the data memory; it is the memory's only driver.
// PARAMETERS
//  DEPTH_WORDS  64  memory depth in 32-bit words; word index >= DEPTH_WORDS is an error
//  M0_FIRST     1   after reset, M0 wins the first tie (0: M1 wins)
// PORTS
//  clk          in   1   clock, all state changes on posedge
//  reset        in   1   asynchronous, active-high
//  mN_req       in   1   request valid, N=0,1; held with fields stable until mN_gnt
//  mN_we        in   1   1 = store, 0 = load
//  mN_addr      in   32  byte address; addr[1:0] ignored
//  mN_wdata     in   32  store data
//  mN_be        in   4   store byte enables; be[i] selects wdata[8i+7:8i]; ignored on loads
//  mN_gnt       out  1   request accepted this cycle (combinational, IDLE only)
//  mN_rvalid    out  1   1-cycle completion pulse for loads and stores
//  mN_rdata     out  32  load data, valid with mN_rvalid; 0 for stores and errors
//  mN_err       out  1   with mN_rvalid: address out of range
//  mem_we       out  1   data-memory write enable
//  mem_addr     out  32  data-memory byte address
//  mem_wdata    out  32  data-memory write data
//  mem_rdata    in   32  data-memory read data (combinational from mem_addr)
// BEHAVIOUR
//  Reset: state=IDLE; all gnt/rvalid/err=0; all rdata=0; mem_we=0; mem_addr=0; mem_wdata=0;
//   rr pointer set per M0_FIRST. Reset mid-transaction aborts it: no rvalid, no memory write.
//   mem_we drops immediately on reset assertion.
//  States: IDLE, ACCESS, MERGE, RESP.
//  IDLE: a single req is granted; if both req, the master not granted last wins.
//   Exactly one mN_gnt high. On the edge, capture winner id, we, addr, wdata, be.
//   -> ACCESS. rr pointer updates only on grant.
//  ACCESS: mem_addr = captured addr.
//   Out of range: no mem_we; err latched -> RESP.
//   Load: latch mem_rdata -> RESP.
//   Store with be==4'hF: mem_we=1, mem_wdata=wdata -> RESP.
//   Store with be==4'h0: no write -> RESP (completes normally).
//   Other partial store: latch merged word (be bytes from wdata, others from mem_rdata) -> MERGE.
//  MERGE: mem_we=1, mem_addr=captured addr, mem_wdata=merged word -> RESP.
//  RESP: the owner gets mN_rvalid=1 (plus rdata/err) for exactly one cycle -> IDLE.
//   The other master's rvalid stays 0.
//  No gnt outside IDLE; requests wait, held by the requester.
//  Latency from the gnt cycle T: rvalid at T+2 for loads, full stores and errors;
//   T+3 for partial stores. Max throughput: one transaction per 3 cycles (4 for RMW).
//  mem_we is never high in IDLE or RESP. mem_we is never high for an out-of-range access.
//  A req raised in RESP is considered in the next IDLE cycle.
//  rdata/err are held until the next rvalid for that master.
// TESTING
//  1) M0 store addr 0x10, wdata 0xDEADBEEF, be F -> gnt T, mem_we T+1; load 0x10 -> rdata 0xDEADBEEF at gnt+2.
//  2) Mem word 0x11223344 @0x20; M1 store be 4'b0101, wdata 0xAABBCCDD -> mem_we only at T+2 with 0x11BB33DD; rvalid T+3.
//  3) M0 and M1 req together for 4 transactions each -> grants alternate M0,M1,M0,...; no starvation, no double gnt.
//  4) M0 load addr 0x100 (word 64) -> m0_err=1, m0_rdata=0 at T+2; mem_we never asserted.
//  5) Assert reset in MERGE of a partial store -> mem_we=0 immediately, no rvalid, memory word unchanged, IDLE after release.
//  6) M1 store be 0 -> rvalid at T+2, memory unchanged; a M0 req held throughout is granted the cycle after RESP.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters (core LSU, debug/DMA) access to one data memory.
// One transaction in flight; partial stores are done as read-modify-write.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 64,
    parameter bit M0_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] MERGE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    logic [1:0]  state;
    logic        owner;
    logic        last_gnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic [31:0] merged_q;
    logic [31:0] merged;
    logic        in_range;
    logic        partial;
    logic        result_load;
    logic [31:0] result_rdata;
    logic        result_err;

    // last_gnt = 1 means M1 was granted last, so M0 wins the next tie
    assign m0_gnt = (state == IDLE) && m0_req && (!m1_req || last_gnt);
    assign m1_gnt = (state == IDLE) && m1_req && (!m0_req || !last_gnt);

    assign in_range = (cap_addr[31:2] < DEPTH_LIM);
    assign partial  = (cap_be != 4'h0) && (cap_be != 4'hF);

    assign m0_rvalid = (state == RESP) && !owner;
    assign m1_rvalid = (state == RESP) && owner;

    assign mem_we    = ((state == ACCESS) && in_range && cap_we && (cap_be == 4'hF))
                     || (state == MERGE);
    assign mem_addr  = cap_addr;
    assign mem_wdata = (state == MERGE) ? merged_q : cap_wdata;

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (cap_be[i]) begin
                merged[8*i +: 8] = cap_wdata[8*i +: 8];
            end
        end
    end

    // Response payload for the owner, committed on the cycle that moves into RESP
    always_comb begin
        result_load  = 1'b0;
        result_rdata = 32'h0;
        result_err   = 1'b0;
        if (state == ACCESS) begin
            if (!in_range) begin
                result_load = 1'b1;
                result_err  = 1'b1;
            end else if (!cap_we) begin
                result_load  = 1'b1;
                result_rdata = mem_rdata;
            end else if (!partial) begin
                result_load = 1'b1;
            end
        end else if (state == MERGE) begin
            result_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last_gnt  <= M0_FIRST;
            cap_we    <= 1'b0;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
            cap_be    <= 4'h0;
            merged_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_gnt || m1_gnt) begin
                        owner     <= m1_gnt;
                        last_gnt  <= m1_gnt;
                        cap_we    <= m1_gnt ? m1_we    : m0_we;
                        cap_addr  <= m1_gnt ? m1_addr  : m0_addr;
                        cap_wdata <= m1_gnt ? m1_wdata : m0_wdata;
                        cap_be    <= m1_gnt ? m1_be    : m0_be;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (in_range && cap_we && partial) begin
                        merged_q <= merged;
                        state    <= MERGE;
                    end else begin
                        state <= RESP;
                    end
                end
                MERGE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Per-master result registers hold their value until that master's next completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata <= 32'h0;
            m0_err   <= 1'b0;
            m1_rdata <= 32'h0;
            m1_err   <= 1'b0;
        end else if (result_load) begin
            if (owner) begin
                m1_rdata <= result_rdata;
                m1_err   <= result_err;
            end else begin
                m0_rdata <= result_rdata;
                m0_err   <= result_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference memory predicts each response at grant time,
// and completions are popped and compared as the arbiter raises rvalid.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    exp_t        sb[$];
    int          gnt_log[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          g0, g1, gx;
    logic [31:0] saved;

    dmem_arbiter #(.DEPTH_WORDS(64), .M0_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: asynchronous read, synchronous write, out-of-range reads return zero
    assign mem_rdata = (mem_addr[31:2] < 30'd64) ? mem[mem_addr[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && (mem_addr[31:2] < 30'd64)) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Raise a request, wait for its grant, predict the response, then drop the request
    task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, output int gcyc);
        bit          got = 0;
        exp_t        e;
        logic [29:0] idx;
        @(posedge clk); #1;
        if (m == 0) begin
            m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
        gcyc = -1;
        for (int w = 0; w < 100 && !got; w++) begin
            @(negedge clk);
            if ((m == 0 && m0_gnt) || (m == 1 && m1_gnt)) got = 1;
        end
        if (!got) begin
            checkOutput("gnt_timeout", 32'd0, 32'd1);
        end else begin
            gcyc    = cyc;
            idx     = addr[31:2];
            e.m     = m;
            e.err   = (idx >= 30'd64);
            e.rdata = 32'h0;
            e.due   = cyc + 2;
            if (!e.err) begin
                if (!we) begin
                    e.rdata = ref_mem[idx[5:0]];
                end else begin
                    if (be != 4'h0 && be != 4'hF) e.due = cyc + 3;
                    for (int i = 0; i < 4; i++)
                        if (be[i]) ref_mem[idx[5:0]][8*i +: 8] = wdata[8*i +: 8];
                end
            end
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (m == 0) m0_req = 0; else m1_req = 0;
    endtask

    task automatic drain();
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
        checkOutput("drain", sb.size(), 0);
        @(posedge clk);
    endtask

    // Completion monitor and always-on protocol checks
    always @(negedge clk) begin
        exp_t e;
        int   m;
        if (!reset) begin
            if (m0_gnt || m1_gnt) begin
                checkOutput("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 32'd0);
                gnt_log.push_back(m1_gnt ? 1 : 0);
            end
            if (mem_we) checkOutput("mem_we_range", {31'b0, mem_addr[31:2] < 30'd64}, 32'd1);
            if (m0_rvalid && m1_rvalid) begin
                checkOutput("rvalid_onehot", 32'd1, 32'd0);
            end else if (m0_rvalid || m1_rvalid) begin
                m = m1_rvalid ? 1 : 0;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_master", m, e.m);
                    checkOutput("resp_rdata", m ? m1_rdata : m0_rdata, e.rdata);
                    checkOutput("resp_err", {31'b0, m ? m1_err : m0_err}, {31'b0, e.err});
                    checkOutput("resp_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_gnt", {30'b0, m0_gnt, m1_gnt}, 32'd0);
        checkOutput("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
        checkOutput("rst_err", {30'b0, m0_err, m1_err}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 0;

        $display("[TB] contention: M0 stores vs M1 loads");
        gnt_log.delete();
        fork
            for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h40 + 4*i, 32'h1000 + i, 4'hF, gx);
            for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'h40 + 4*i, 32'h0, 4'h0, gx);
        join
        drain();
        checkOutput("rr_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) checkOutput("rr_order", gnt_log[i], i % 2);

        $display("[TB] full store then load");
        applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, g0);
        checkOutput("full_we", {31'b0, mem_we}, 32'd1);
        checkOutput("full_addr", mem_addr, 32'h10);
        checkOutput("full_wdata", mem_wdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 32'h10, 32'h0, 4'h0, g0);
        drain();

        $display("[TB] partial store read-modify-write");
        applyStimulus(0, 1, 32'h20, 32'h11223344, 4'hF, g0);
        drain();
        applyStimulus(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101, g1);
        checkOutput("rmw_access_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        checkOutput("rmw_merge_we", {31'b0, mem_we}, 32'd1);
        checkOutput("rmw_merge_wdata", mem_wdata, 32'h11BB33DD);
        checkOutput("rmw_merge_addr", mem_addr, 32'h20);
        drain();
        checkOutput("rmw_mem_word", mem[8], 32'h11BB33DD);

        $display("[TB] out-of-range load");
        applyStimulus(0, 0, 32'h100, 32'h0, 4'h0, g0);
        checkOutput("oor_we", {31'b0, mem_we}, 32'd0);
        drain();

        $display("[TB] reset during merge");
        applyStimulus(0, 1, 32'h30, 32'h55667788, 4'hF, g0);
        drain();
        saved = ref_mem[12];
        applyStimulus(0, 1, 32'h30, 32'h12345678, 4'b0011, g0);
        @(posedge clk); #1;
        checkOutput("abort_merge_we", {31'b0, mem_we}, 32'd1);
        #2 reset = 1;
        #1;
        checkOutput("abort_we_drop", {31'b0, mem_we}, 32'd0);
        sb.delete();
        ref_mem[12] = saved;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        repeat (3) @(posedge clk);
        checkOutput("abort_mem_word", mem[12], 32'h55667788);
        applyStimulus(0, 0, 32'h30, 32'h0, 4'h0, g0);
        drain();

        $display("[TB] empty-enable store with M0 waiting");
        applyStimulus(0, 1, 32'h44, 32'hCAFEF00D, 4'hF, g0);
        drain();
        fork
            applyStimulus(1, 1, 32'h44, 32'hFFFFFFFF, 4'h0, g1);
            begin
                @(posedge clk);
                applyStimulus(0, 0, 32'h44, 32'h0, 4'h0, g0);
            end
        join
        drain();
        checkOutput("be0_wait_gnt", g0 - g1, 3);
        checkOutput("be0_mem_word", mem[17], 32'hCAFEF00D);
        checkOutput("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
